data_memory_controller: RTL and testbench

- Sits directly downstream of the load/store control FSM and carries out one data-memory access per memory_start.
- Handles RV64 byte, half, word and double accesses, signed and unsigned.
- Drives a 64-bit doubleword-aligned memory bus with byte strobes and a req/ack handshake.
- Returns load data already extended, and pulses memory_done when the access completes.

---
 rtl/data_memory_controller.sv | 193 +++++++++++++++++++
 tb/tb_data_memory_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_controller.sv
// Data-memory access unit: one RV64 load/store per memory_start over a 64-bit doubleword bus.
// Define MEM_SPLIT_ACCESS_EN to split doubleword-crossing accesses into two beats; otherwise they are flagged misaligned.
module data_memory_controller #(
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_start,
   input  logic                  sel_mem_operation,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [63:0]           store_data,
   output logic                  memory_done,
   output logic [63:0]           load_data,
   output logic                  misaligned,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [63:0]           mem_wdata,
   output logic [7:0]            mem_wstrb,
   input  logic [63:0]           mem_rdata,
   input  logic                  mem_ack
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FINISH} state_e;

   state_e                  state_q, state_d;
   logic                    op_q;
   logic [2:0]              f3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [63:0]             sdata_q;
   logic [63:0]             load_q, load_d;
   logic                    latch_en;
   logic [3:0]              n_in, n_q;
   logic [2:0]              o_q;
   logic                    cross_in;
   logic [ADDR_WIDTH-1:0]   base_addr;
   logic [7:0]              strb0;
   logic [63:0]             wdata0;
`ifdef MEM_SPLIT_ACCESS_EN
   logic                    cross_q;
   logic                    cap0;
   logic [63:0]             rdata0_q;
   logic [15:0]             wide_s;
   logic [127:0]            wide_w;
`else
   logic                    mis_q, mis_d;
`endif

   // Shift the raw bytes down to the access offset, then extend to 64 bits.
   function automatic logic [63:0] load_extend(input logic [127:0] raw,
                                               input logic [2:0]   off,
                                               input logic [2:0]   f3);
      logic [63:0] s;
      logic        sx;
      s  = 64'(raw >> {off, 3'b000});
      sx = ~f3[2];
      case (f3[1:0])
         2'b00:   load_extend = {{56{sx & s[7]}},  s[7:0]};
         2'b01:   load_extend = {{48{sx & s[15]}}, s[15:0]};
         2'b10:   load_extend = {{32{sx & s[31]}}, s[31:0]};
         default: load_extend = s;
      endcase
   endfunction

   assign n_in      = 4'd1 << funct3[1:0];
   assign cross_in  = ({1'b0, address[2:0]} + n_in) > 4'd8;
   assign n_q       = 4'd1 << f3_q[1:0];
   assign o_q       = addr_q[2:0];
   assign base_addr = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign load_data = load_q;

`ifdef MEM_SPLIT_ACCESS_EN
   assign wide_s = ((16'h1 << n_q) - 16'h1) << o_q;
   assign wide_w = {64'b0, sdata_q} << {o_q, 3'b000};
   assign strb0  = wide_s[7:0];
   assign wdata0 = wide_w[63:0];
`else
   assign strb0  = 8'(((16'h1 << n_q) - 16'h1) << o_q);
   assign wdata0 = sdata_q << {o_q, 3'b000};
`endif

   always_comb begin
      state_d     = state_q;
      load_d      = load_q;
      latch_en    = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      memory_done = 1'b0;
      misaligned  = 1'b0;
`ifdef MEM_SPLIT_ACCESS_EN
      cap0        = 1'b0;
`else
      mis_d       = mis_q;
`endif
      case (state_q)
         IDLE: begin
            if (memory_start) begin
               latch_en = 1'b1;
`ifdef MEM_SPLIT_ACCESS_EN
               state_d  = BEAT0;
`else
               mis_d    = cross_in;
               if (cross_in) begin
                  state_d = FINISH;
                  load_d  = '0;
               end else begin
                  state_d = BEAT0;
               end
`endif
            end
         end
         BEAT0: begin
            mem_req   = 1'b1;
            mem_we    = op_q;
            mem_addr  = base_addr;
            mem_wdata = wdata0;
            mem_wstrb = op_q ? strb0 : 8'h00;
            if (mem_ack) begin
`ifdef MEM_SPLIT_ACCESS_EN
               if (cross_q) begin
                  cap0    = 1'b1;
                  state_d = BEAT1;
               end else begin
                  state_d = FINISH;
                  if (!op_q) load_d = load_extend({64'b0, mem_rdata}, o_q, f3_q);
               end
`else
               state_d = FINISH;
               if (!op_q) load_d = load_extend({64'b0, mem_rdata}, o_q, f3_q);
`endif
            end
         end
`ifdef MEM_SPLIT_ACCESS_EN
         BEAT1: begin
            mem_req   = 1'b1;
            mem_we    = op_q;
            mem_addr  = base_addr + ADDR_WIDTH'(8);
            mem_wdata = wide_w[127:64];
            mem_wstrb = op_q ? wide_s[15:8] : 8'h00;
            if (mem_ack) begin
               state_d = FINISH;
               if (!op_q) load_d = load_extend({mem_rdata, rdata0_q}, o_q, f3_q);
            end
         end
`endif
         FINISH: begin
            memory_done = 1'b1;
`ifndef MEM_SPLIT_ACCESS_EN
            misaligned  = mis_q;
`endif
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         load_q  <= '0;
`ifndef MEM_SPLIT_ACCESS_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
`ifndef MEM_SPLIT_ACCESS_EN
         mis_q   <= mis_d;
`endif
      end
   end

   // Request fields are only meaningful while the FSM is busy, so they carry no reset.
   always_ff @(posedge clk) begin
      if (latch_en) begin
         op_q    <= sel_mem_operation;
         f3_q    <= funct3;
         addr_q  <= address;
         sdata_q <= store_data;
`ifdef MEM_SPLIT_ACCESS_EN
         cross_q <= cross_in;
`endif
      end
`ifdef MEM_SPLIT_ACCESS_EN
      if (cap0) rdata0_q <= mem_rdata;
`endif
   end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller; covers the split or misaligned path matching the build macro.
module tb_data_memory_controller;
   localparam int AW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          memory_start;
   logic          sel_mem_operation;
   logic [2:0]    funct3;
   logic [AW-1:0] address;
   logic [63:0]   store_data;
   logic          memory_done;
   logic [63:0]   load_data;
   logic          misaligned;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [63:0]   mem_wdata;
   logic [7:0]    mem_wstrb;
   logic [63:0]   mem_rdata;
   logic          mem_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory_controller #(.ADDR_WIDTH(AW)) dut (
      .clk               (clk),
      .reset             (reset),
      .memory_start      (memory_start),
      .sel_mem_operation (sel_mem_operation),
      .funct3            (funct3),
      .address           (address),
      .store_data        (store_data),
      .memory_done       (memory_done),
      .load_data         (load_data),
      .misaligned        (misaligned),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_wstrb         (mem_wstrb),
      .mem_rdata         (mem_rdata),
      .mem_ack           (mem_ack)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic op, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] d);
      memory_start      = 1'b1;
      sel_mem_operation = op;
      funct3            = f3;
      address           = a;
      store_data        = d;
   endtask

   initial begin
      reset = 1'b1; memory_start = 1'b0; sel_mem_operation = 1'b0; funct3 = 3'b000;
      address = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
      tick; tick;
      chk("rst_req",   64'(mem_req),     64'h0);
      chk("rst_we",    64'(mem_we),      64'h0);
      chk("rst_done",  64'(memory_done), 64'h0);
      chk("rst_mis",   64'(misaligned),  64'h0);
      chk("rst_addr",  mem_addr,         64'h0);
      chk("rst_wdata", mem_wdata,        64'h0);
      chk("rst_wstrb", 64'(mem_wstrb),   64'h0);
      chk("rst_load",  load_data,        64'h0);

      reset = 1'b0; mem_ack = 1'b1;
      tick;
      chk("idle_ack_req",  64'(mem_req),     64'h0);
      chk("idle_ack_done", 64'(memory_done), 64'h0);
      mem_ack = 1'b0;

      // lw at 0x1000
      start_op(1'b0, 3'b010, 64'h1000, 64'h0);
      tick;
      chk("lw_req",   64'(mem_req),     64'h1);
      chk("lw_addr",  mem_addr,         64'h1000);
      chk("lw_wstrb", 64'(mem_wstrb),   64'h0);
      chk("lw_we",    64'(mem_we),      64'h0);
      chk("lw_early", 64'(memory_done), 64'h0);
      mem_ack = 1'b1; mem_rdata = 64'h0000_0000_8000_0001;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("lw_done",  64'(memory_done), 64'h1);
      chk("lw_reqf",  64'(mem_req),     64'h0);
      chk("lw_data",  load_data,        64'hFFFF_FFFF_8000_0001);
      tick;
      chk("lw_pulse", 64'(memory_done), 64'h0);
      chk("lw_hold",  load_data,        64'hFFFF_FFFF_8000_0001);

      // lbu at 0x1003
      start_op(1'b0, 3'b100, 64'h1003, 64'h0);
      tick;
      chk("lbu_addr", mem_addr, 64'h1000);
      mem_ack = 1'b1; mem_rdata = 64'h0000_0000_AB00_0000;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("lbu_done", 64'(memory_done), 64'h1);
      chk("lbu_data", load_data,        64'h0000_0000_0000_00AB);
      tick;

      // lb at 0x1003
      start_op(1'b0, 3'b000, 64'h1003, 64'h0);
      tick;
      mem_ack = 1'b1;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("lb_done", 64'(memory_done), 64'h1);
      chk("lb_data", load_data,        64'hFFFF_FFFF_FFFF_FFAB);
      tick;

      // sw at 0x2004
      start_op(1'b1, 3'b010, 64'h2004, 64'h1122_3344_DEAD_BEEF);
      tick;
      chk("sw_we",    64'(mem_we),          64'h1);
      chk("sw_addr",  mem_addr,             64'h2000);
      chk("sw_wstrb", 64'(mem_wstrb),       64'hF0);
      chk("sw_wdata", 64'(mem_wdata[63:32]), 64'hDEAD_BEEF);
      mem_ack = 1'b1;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("sw_done", 64'(memory_done), 64'h1);
      chk("sw_keep", load_data,        64'hFFFF_FFFF_FFFF_FFAB);
      tick;

      // ld at 0x3000, ack after 3 wait cycles; start held and address input disturbed
      start_op(1'b0, 3'b011, 64'h3000, 64'h0);
      tick;
      address = 64'h5555_0000;
      for (int i = 0; i < 4; i++) begin
         chk("ld_req",   64'(mem_req),     64'h1);
         chk("ld_addr",  mem_addr,         64'h3000);
         chk("ld_wstrb", 64'(mem_wstrb),   64'h0);
         chk("ld_wait",  64'(memory_done), 64'h0);
         if (i < 3) tick;
      end
      mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("ld_done", 64'(memory_done), 64'h1);
      chk("ld_data", load_data,        64'h0123_4567_89AB_CDEF);
      tick;

      // lh at 0x1003: unaligned but within one doubleword
      start_op(1'b0, 3'b001, 64'h1003, 64'h0);
      tick;
      chk("lh_addr", mem_addr, 64'h1000);
      mem_ack = 1'b1; mem_rdata = 64'h0000_00F0_1200_0000;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("lh_done", 64'(memory_done), 64'h1);
      chk("lh_mis",  64'(misaligned),  64'h0);
      chk("lh_data", load_data,        64'hFFFF_FFFF_FFFF_F012);
      tick;

`ifdef MEM_SPLIT_ACCESS_EN
      // sh at 0x2007 split over two beats
      start_op(1'b1, 3'b001, 64'h2007, 64'h0000_0000_0000_BEEF);
      tick;
      chk("sh_b0_addr",  mem_addr,               64'h2000);
      chk("sh_b0_wstrb", 64'(mem_wstrb),         64'h80);
      chk("sh_b0_wdata", 64'(mem_wdata[63:56]),  64'hEF);
      mem_ack = 1'b1;
      tick;
      chk("sh_b1_req",   64'(mem_req),           64'h1);
      chk("sh_b1_addr",  mem_addr,               64'h2008);
      chk("sh_b1_wstrb", 64'(mem_wstrb),         64'h01);
      chk("sh_b1_wdata", 64'(mem_wdata[7:0]),    64'hBE);
      chk("sh_b1_done",  64'(memory_done),       64'h0);
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("sh_done", 64'(memory_done), 64'h1);
      chk("sh_mis",  64'(misaligned),  64'h0);
      chk("sh_keep", load_data,        64'hFFFF_FFFF_FFFF_F012);
      tick;

      // lw at 0x1006 split load
      start_op(1'b0, 3'b010, 64'h1006, 64'h0);
      tick;
      mem_ack = 1'b1; mem_rdata = 64'hAABB_0000_0000_0000;
      tick;
      chk("lws_b1_addr", mem_addr, 64'h1008);
      mem_rdata = 64'h0000_0000_0000_CCDD;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("lws_done", 64'(memory_done), 64'h1);
      chk("lws_data", load_data,        64'hFFFF_FFFF_CCDD_AABB);
      tick;
`else
      // sw at 0x3006 crosses a doubleword: flagged, no bus traffic
      start_op(1'b1, 3'b010, 64'h3006, 64'h0000_0000_1234_5678);
      tick;
      memory_start = 1'b0;
      chk("mis_req",  64'(mem_req),     64'h0);
      chk("mis_done", 64'(memory_done), 64'h1);
      chk("mis_flag", 64'(misaligned),  64'h1);
      chk("mis_load", load_data,        64'h0);
      tick;
      chk("mis_done_pulse", 64'(memory_done), 64'h0);
      chk("mis_flag_pulse", 64'(misaligned),  64'h0);
`endif

      // reset while BEAT0 waits for ack
      start_op(1'b0, 3'b011, 64'h4000, 64'h0);
      tick;
      chk("rmid_req", 64'(mem_req), 64'h1);
      reset = 1'b1; memory_start = 1'b0;
      tick;
      chk("rmid_req0", 64'(mem_req),     64'h0);
      chk("rmid_done", 64'(memory_done), 64'h0);
      chk("rmid_addr", mem_addr,         64'h0);
      chk("rmid_load", load_data,        64'h0);
      reset = 1'b0; mem_ack = 1'b1;
      tick;
      chk("rmid_after", 64'(memory_done), 64'h0);
      mem_ack = 1'b0;
      start_op(1'b0, 3'b100, 64'h4001, 64'h0);
      tick;
      chk("rnew_addr", mem_addr, 64'h4000);
      mem_ack = 1'b1; mem_rdata = 64'h0000_0000_0000_7F00;
      tick;
      memory_start = 1'b0; mem_ack = 1'b0;
      chk("rnew_done", 64'(memory_done), 64'h1);
      chk("rnew_data", load_data,        64'h0000_0000_0000_007F);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
